fantasy_grade: RTL and testbench

Parametrised successor to the per-pixel tone stage of the fantasy video path. It applies an optional inversion, a signed shift and a gain to CH channels of DW bits per pixel, in a fixed-latency pipeline, under one of eight modes driven by the block-statistics flags. Compared with the previous generation it adds three things: frame-synchronous mode switching, a global master gain that ramps per frame, and saturating output arithmetic. It sits between the block buffer and the video output, and its sync outputs are delay-matched to the data.

---
 rtl/fantasy_pkg.sv | 22 ++
 rtl/fantasy_grade_chan.sv | 48 ++++
 rtl/fantasy_grade.sv | 172 +++++++++++++++++
 tb/tb_fantasy_grade.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fantasy_pkg.sv
// Shared mode encoding and gain constants for the fantasy_grade tone stage.
package fantasy_pkg;

  typedef enum logic [2:0] {
    MODE_INV      = 3'd0,
    MODE_INV_2_3  = 3'd1,
    MODE_BLK_Y    = 3'd2,
    MODE_BLK_C    = 3'd3,
    MODE_CHROMA   = 3'd4,
    MODE_DIM      = 3'd5,
    MODE_PASS     = 3'd6,
    MODE_PASS_ALT = 3'd7
  } mode_t;

  // Gains are unsigned Q1.15, so GAIN_ONE is unity.
  localparam int GAIN_FRAC     = 15;
  localparam int GAIN_ONE      = 32768;
  localparam int GAIN_2_3      = 21845;
  localparam int GAIN_1_2      = 16384;
  localparam int C_THR_DEFAULT = 89;

endpackage

// File: rtl/fantasy_grade_chan.sv
// One colour channel of the grade pipeline: offset, gain multiply and
// saturation to the output range (pipeline stages 2 to 4).
module fantasy_grade_chan
  import fantasy_pkg::*;
#(
  parameter int DW = 8,
  parameter int GW = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        pixel,
  input  logic                 inv,
  input  logic signed [DW+1:0] shift,
  input  logic [GW-1:0]        gain,
  output logic [DW-1:0]        y
);

  localparam int PW = DW + GW + 3;

  logic signed [DW+1:0] d;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic [DW-1:0]        clamped;

  // Truncating arithmetic shift, then clip to 0 .. 2^DW-1.
  always_comb begin
    scaled  = prod >>> GAIN_FRAC;
    clamped = scaled[DW-1:0];
    if (scaled[PW-1]) begin
      clamped = '0;
    end else if (|scaled[PW-2:DW]) begin
      clamped = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d    <= '0;
      prod <= '0;
      y    <= '0;
    end else begin
      d    <= signed'({2'b00, inv ? ~pixel : pixel}) - shift;
      prod <= d * signed'({1'b0, gain});
      y    <= clamped;
    end
  end

endmodule

// File: rtl/fantasy_grade.sv
// fantasy_grade: four-stage per-pixel tone stage with frame-synchronous mode and master gain.
// Define FANTASY_GRADE_RAMP_EN to ramp the master gain by RAMP_STEP per frame instead of jumping.
module fantasy_grade
  import fantasy_pkg::*;
#(
  parameter int CH        = 3,
  parameter int DW        = 8,
  parameter int GW        = 17,
  parameter int RAMP_STEP = 2048,
  parameter int C_THR     = C_THR_DEFAULT
) (
  input  logic             vin_clk_i,
  input  logic             rst_i,
  input  logic [2:0]       mode_i,
  input  logic [GW-1:0]    gain_tgt_i,
  input  logic             vin_hs_i,
  input  logic             vin_vs_i,
  input  logic             vin_de_i,
  input  logic [CH*DW-1:0] vin_data_i,
  input  logic             blk_y_i,
  input  logic             blk_c_i,
  input  logic             blk_l_i,
  input  logic [DW-1:0]    px_c_i,
  input  logic [DW-1:0]    px_l_i,
  output logic             vout_hs_o,
  output logic             vout_vs_o,
  output logic             vout_de_o,
  output logic [CH*DW-1:0] vout_data_o,
  output logic             ramp_busy_o
);

`ifdef FANTASY_GRADE_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif
  // A full-scale step reaches any target in one frame start.
  localparam logic [GW-1:0]        STEP       = RAMP_EN ? GW'(RAMP_STEP) : {GW{1'b1}};
  localparam logic [DW-1:0]        CHROMA_THR = DW'(C_THR);
  localparam logic signed [DW+1:0] MID        = (DW+2)'(1 << (DW-1));

  logic          vs_q;
  logic          frame_start;
  mode_t         mode_q;
  logic [GW-1:0] gmaster;
  logic [GW-1:0] gmaster_next;

  logic                 inv;
  logic signed [DW+1:0] shift;
  logic [GW-1:0]        mgain;
  logic signed [DW+1:0] lum;
  logic signed [DW+1:0] diff;

  logic [CH*DW-1:0]     data1;
  logic                 inv1;
  logic signed [DW+1:0] shift1;
  logic [GW-1:0]        mgain1;
  logic [GW-1:0]        gm1;
  logic [2:0]           sync1, sync2, sync3, sync4;
  logic [GW-1:0]        g2;
  logic [2*GW-1:0]      gprod;
  logic [2*GW-1:0]      gscaled;
  logic [GW-1:0]        gsat;

  assign frame_start = vin_vs_i & ~vs_q;
  assign ramp_busy_o = (gmaster != gain_tgt_i);

  always_comb begin
    gmaster_next = gmaster;
    if (gmaster < gain_tgt_i) begin
      gmaster_next = (gain_tgt_i - gmaster > STEP) ? gmaster + STEP : gain_tgt_i;
    end else if (gmaster > gain_tgt_i) begin
      gmaster_next = (gmaster - gain_tgt_i > STEP) ? gmaster - STEP : gain_tgt_i;
    end
  end

  // Mode and master gain only change on the edge that sees the vs rise.
  always_ff @(posedge vin_clk_i) begin
    if (rst_i) begin
      vs_q    <= 1'b0;
      mode_q  <= MODE_PASS;
      gmaster <= GW'(GAIN_ONE);
    end else begin
      vs_q <= vin_vs_i;
      if (frame_start) begin
        mode_q  <= mode_t'(mode_i);
        gmaster <= gmaster_next;
      end
    end
  end

  always_comb begin
    inv   = 1'b0;
    shift = '0;
    mgain = GW'(GAIN_ONE);
    lum   = signed'({2'b00, px_l_i});
    diff  = lum - signed'({3'b000, px_c_i[DW-1:1]});
    case (mode_q)
      MODE_INV:     inv = 1'b1;
      MODE_INV_2_3: begin
        inv   = 1'b1;
        mgain = GW'(GAIN_2_3);
      end
      MODE_BLK_Y:   inv = blk_y_i;
      MODE_BLK_C: begin
        inv   = ~blk_c_i & blk_y_i;
        mgain = blk_c_i ? GW'(GAIN_1_2) : GW'(GAIN_ONE);
      end
      MODE_CHROMA: begin
        if (px_c_i < CHROMA_THR) begin
          if (blk_l_i) shift = (lum - MID) <<< 1;
        end else begin
          // Adding the sign bit before the shift makes the halving truncate toward zero.
          shift = (diff + signed'({{(DW+1){1'b0}}, diff[DW+1]})) >>> 1;
          if (blk_l_i) mgain = GW'(GAIN_2_3);
        end
      end
      MODE_DIM:     mgain = GW'(GAIN_2_3);
      default:      ;
    endcase
  end

  always_comb begin
    gprod   = mgain1 * gm1;
    gscaled = gprod >> GAIN_FRAC;
    gsat    = (|gscaled[2*GW-1:GW]) ? {GW{1'b1}} : gscaled[GW-1:0];
  end

  always_ff @(posedge vin_clk_i) begin
    if (rst_i) begin
      data1  <= '0;
      inv1   <= 1'b0;
      shift1 <= '0;
      mgain1 <= '0;
      gm1    <= '0;
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      sync4  <= '0;
      g2     <= '0;
    end else begin
      data1  <= vin_data_i;
      inv1   <= inv;
      shift1 <= shift;
      mgain1 <= mgain;
      gm1    <= gmaster;
      sync1  <= {vin_hs_i, vin_vs_i, vin_de_i};
      sync2  <= sync1;
      sync3  <= sync2;
      sync4  <= sync3;
      g2     <= gsat;
    end
  end

  assign {vout_hs_o, vout_vs_o, vout_de_o} = sync4;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    fantasy_grade_chan #(
      .DW(DW),
      .GW(GW)
    ) u_chan (
      .clk  (vin_clk_i),
      .rst  (rst_i),
      .pixel(data1[(CH-1-c)*DW +: DW]),
      .inv  (inv1),
      .shift(shift1),
      .gain (g2),
      .y    (vout_data_o[(CH-1-c)*DW +: DW])
    );
  end

endmodule

// File: tb/tb_fantasy_grade.sv
// Self-checking bench for fantasy_grade: directed vector table, hand-written
// frame sequences and randomized traffic against a behavioural model.
module tb_fantasy_grade;

  localparam int CH    = 3;
  localparam int DW    = 8;
  localparam int GW    = 17;
  localparam int RSTEP = 4096;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [2:0]       mode_i = 3'd6;
  logic [GW-1:0]    gain_tgt_i = 17'd32768;
  logic             vin_hs_i = 1'b0, vin_vs_i = 1'b0, vin_de_i = 1'b0;
  logic [CH*DW-1:0] vin_data_i = '0;
  logic             blk_y_i = 1'b0, blk_c_i = 1'b0, blk_l_i = 1'b0;
  logic [DW-1:0]    px_c_i = '0, px_l_i = '0;
  logic             vout_hs_o, vout_vs_o, vout_de_o;
  logic [CH*DW-1:0] vout_data_o;
  logic             ramp_busy_o;

  always #5 clk = ~clk;

  fantasy_grade #(
    .CH(CH), .DW(DW), .GW(GW), .RAMP_STEP(RSTEP), .C_THR(89)
  ) dut (
    .vin_clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .gain_tgt_i(gain_tgt_i),
    .vin_hs_i(vin_hs_i), .vin_vs_i(vin_vs_i), .vin_de_i(vin_de_i),
    .vin_data_i(vin_data_i), .blk_y_i(blk_y_i), .blk_c_i(blk_c_i),
    .blk_l_i(blk_l_i), .px_c_i(px_c_i), .px_l_i(px_l_i),
    .vout_hs_o(vout_hs_o), .vout_vs_o(vout_vs_o), .vout_de_o(vout_de_o),
    .vout_data_o(vout_data_o), .ramp_busy_o(ramp_busy_o)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  mode;
    logic [16:0] tgt;
    logic        hs, vs, de;
    logic [23:0] data;
    logic        by, bc, bl;
    logic [7:0]  pc, pl;
  } stim_t;

  typedef struct {
    logic [23:0]  data;
    logic [2:0]   sync;
    bit           has_const;
    logic [23:0]  const_val;
    logic [127:0] label;
  } exp_t;

  typedef struct {
    logic [127:0] label;
    logic [2:0]   mode;
    logic [23:0]  pix;
    logic         by, bc, bl;
    logic [7:0]   pc, pl;
    logic [23:0]  expv;
  } vec_t;

  exp_t  q[$];
  int    total = 0;
  int    bad = 0;
  bit    armed = 0;
  int    m_mode = 6;
  int    m_gm = 32768;
  int    m_tgt = 32768;
  bit    m_vsp = 0;
  stim_t b;

  function automatic int stepGain(int cur, int tgt);
`ifdef FANTASY_GRADE_RAMP_EN
    if (cur < tgt) return (tgt - cur > RSTEP) ? cur + RSTEP : tgt;
    if (cur > tgt) return (cur - tgt > RSTEP) ? cur - RSTEP : tgt;
    return cur;
`else
    return tgt;
`endif
  endfunction

  // Grade one pixel from the rules using the model's current mode and master gain.
  function automatic logic [23:0] modelPixel(stim_t s);
    int inv, shift, mg, g, p, d, pc, pl;
    longint prod, y;
    logic [23:0] out;
    pc = int'(s.pc);
    pl = int'(s.pl);
    inv = 0; shift = 0; mg = 32768;
    case (m_mode)
      0: inv = 1;
      1: begin inv = 1; mg = 21845; end
      2: inv = int'(s.by);
      3: begin inv = (!s.bc && s.by) ? 1 : 0; mg = s.bc ? 16384 : 32768; end
      4: begin
        if (pc < 89) shift = s.bl ? 2 * (pl - 128) : 0;
        else begin
          shift = (pl - pc / 2) / 2;
          mg = s.bl ? 21845 : 32768;
        end
      end
      5: mg = 21845;
      default: ;
    endcase
    g = int'((longint'(mg) * longint'(m_gm)) >> 15);
    if (g > 131071) g = 131071;
    out = '0;
    for (int c = 0; c < 3; c++) begin
      p = int'(s.data[8*(2-c) +: 8]);
      if (inv != 0) p = 255 - p;
      d = p - shift;
      prod = longint'(d) * longint'(g);
      if (prod <= 0) y = 0;
      else begin
        y = prod >> 15;
        if (y > 255) y = 255;
      end
      out[8*(2-c) +: 8] = y[7:0];
    end
    return out;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (armed) begin
      total++;
      if (ramp_busy_o !== ((m_gm != m_tgt) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("[TB] FAIL ramp_busy: got %b want %b", ramp_busy_o, (m_gm != m_tgt));
      end
    end
    if (q.size() >= 4) begin
      e = q.pop_front();
      total++;
      if (vout_data_o !== e.data) begin
        bad++;
        $display("[TB] FAIL data: got %h want %h", vout_data_o, e.data);
      end
      total++;
      if ({vout_hs_o, vout_vs_o, vout_de_o} !== e.sync) begin
        bad++;
        $display("[TB] FAIL syncs: got %b want %b", {vout_hs_o, vout_vs_o, vout_de_o}, e.sync);
      end
      if (e.has_const) begin
        total++;
        if (vout_data_o !== e.const_val) begin
          bad++;
          $display("[TB] FAIL %0s: got %h want %h", e.label, vout_data_o, e.const_val);
        end
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s, input bit hc, input logic [23:0] cv,
                               input logic [127:0] nm);
    exp_t e;
    @(negedge clk);
    checkOutput();
    rst_i = s.rst; mode_i = s.mode; gain_tgt_i = s.tgt;
    vin_hs_i = s.hs; vin_vs_i = s.vs; vin_de_i = s.de; vin_data_i = s.data;
    blk_y_i = s.by; blk_c_i = s.bc; blk_l_i = s.bl; px_c_i = s.pc; px_l_i = s.pl;
    if (s.rst) begin
      q.delete();
      repeat (4) q.push_back('{data: 24'h0, sync: 3'b000, has_const: 1'b1,
                               const_val: 24'h0, label: "reset_flush"});
      m_mode = 6; m_gm = 32768; m_vsp = 0; m_tgt = int'(s.tgt);
      armed = 1;
    end else begin
      e.data = modelPixel(s);
      e.sync = {s.hs, s.vs, s.de};
      e.has_const = hc;
      e.const_val = cv;
      e.label = nm;
      q.push_back(e);
      if (s.vs && !m_vsp) begin
        m_mode = int'(s.mode);
        m_gm = stepGain(m_gm, int'(s.tgt));
      end
      m_vsp = s.vs;
      m_tgt = int'(s.tgt);
    end
  endtask

  task automatic checkBusy(input logic [127:0] nm, input logic expv);
    total++;
    if (ramp_busy_o !== expv) begin
      bad++;
      $display("[TB] FAIL %0s: got %b want %b", nm, ramp_busy_o, expv);
    end
  endtask

  task automatic idle(input int n);
    stim_t s;
    s = b; s.de = 1'b0; s.vs = 1'b0; s.hs = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus(s, 1'b0, 24'h0, "");
  endtask

  task automatic frameStart();
    stim_t s;
    s = b; s.vs = 1'b1; s.de = 1'b0;
    applyStimulus(s, 1'b0, 24'h0, "");
  endtask

  task automatic pixelConst(input logic [23:0] pix, input logic [23:0] cv,
                            input logic [127:0] nm);
    stim_t s;
    s = b; s.de = 1'b1; s.vs = 1'b0; s.data = pix;
    applyStimulus(s, 1'b1, cv, nm);
  endtask

  vec_t vecs[12];
  int   ramp_lvl[5];
  logic [23:0] post_frame;
  int   fc;

  initial begin
    vecs[0]  = '{"pass6",      3'd6, 24'h4080C0, 0, 0, 0, 8'd0,   8'd0,   24'h4080C0};
    vecs[1]  = '{"inv0",       3'd0, 24'h4080C0, 0, 0, 0, 8'd0,   8'd0,   24'hBF7F3F};
    vecs[2]  = '{"inv_dim1",   3'd1, 24'h000000, 0, 0, 0, 8'd0,   8'd0,   24'hA9A9A9};
    vecs[3]  = '{"blky2",      3'd2, 24'h00FF10, 1, 0, 0, 8'd0,   8'd0,   24'hFF00EF};
    vecs[4]  = '{"blkc3_half", 3'd3, 24'h80FF02, 1, 1, 0, 8'd0,   8'd0,   24'h407F01};
    vecs[5]  = '{"blkc3_inv",  3'd3, 24'h00FF10, 1, 0, 0, 8'd0,   8'd0,   24'hFF00EF};
    vecs[6]  = '{"sat_hi4",    3'd4, 24'hFFFFFF, 0, 0, 1, 8'd0,   8'd0,   24'hFFFFFF};
    vecs[7]  = '{"sat_lo4",    3'd4, 24'h101010, 0, 0, 1, 8'd0,   8'd255, 24'h000000};
    vecs[8]  = '{"chroma4",    3'd4, 24'h80FF40, 0, 0, 0, 8'd100, 8'd200, 24'h35B400};
    vecs[9]  = '{"chroma_neg4",3'd4, 24'h000010, 0, 0, 1, 8'd200, 8'd10,  24'h1D1D28};
    vecs[10] = '{"dim5",       3'd5, 24'hFFFFFF, 0, 0, 0, 8'd0,   8'd0,   24'hA9A9A9};
    vecs[11] = '{"pass7",      3'd7, 24'h123456, 0, 0, 0, 8'd0,   8'd0,   24'h123456};
`ifdef FANTASY_GRADE_RAMP_EN
    ramp_lvl = '{223, 191, 159, 127, 127};
    post_frame = 24'hA76F37;
`else
    ramp_lvl = '{127, 127, 127, 127, 127};
    post_frame = 24'h5F3F1F;
`endif

    b = '{rst: 1'b1, mode: 3'd6, tgt: 17'd32768, hs: 0, vs: 0, de: 0, data: 24'h0,
          by: 0, bc: 0, bl: 0, pc: 8'd0, pl: 8'd0};
    repeat (3) applyStimulus(b, 1'b0, 24'h0, "");
    b.rst = 1'b0;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      b.mode = vecs[i].mode;
      b.by = vecs[i].by; b.bc = vecs[i].bc; b.bl = vecs[i].bl;
      b.pc = vecs[i].pc; b.pl = vecs[i].pl;
      frameStart();
      pixelConst(vecs[i].pix, vecs[i].expv, vecs[i].label);
      idle(2);
    end

    b.by = 0; b.bc = 0; b.bl = 0; b.pc = 0; b.pl = 0;
    b.mode = 3'd6;
    frameStart();
    pixelConst(24'h4080C0, 24'h4080C0, "mode6_frame");
    b.mode = 3'd0;
    idle(2);
    pixelConst(24'h4080C0, 24'h4080C0, "mode_hold");
    idle(2);
    frameStart();
    pixelConst(24'h4080C0, 24'hBF7F3F, "mode_switch");
    idle(4);

    b.mode = 3'd6; b.tgt = 17'd16384;
    for (int n = 0; n < 5; n++) begin
      frameStart();
      pixelConst(24'hFFFFFF, {3{ramp_lvl[n][7:0]}}, "ramp_frame");
`ifdef FANTASY_GRADE_RAMP_EN
      checkBusy("ramp_busy_seq", (n < 3) ? 1'b1 : 1'b0);
`else
      checkBusy("ramp_busy_seq", 1'b0);
`endif
      idle(3);
    end

    b.mode = 3'd0;
    b.hs = 1'b1; b.de = 1'b1; b.data = 24'h4080C0;
    repeat (3) applyStimulus(b, 1'b0, 24'h0, "");
    b.rst = 1'b1;
    applyStimulus(b, 1'b0, 24'h0, "");
    b.rst = 1'b0; b.hs = 1'b0; b.de = 1'b0;
    pixelConst(24'h4080C0, 24'h4080C0, "post_rst_pass");
    checkBusy("post_rst_busy", 1'b1);
    idle(2);
    frameStart();
    pixelConst(24'h4080C0, post_frame, "post_rst_frame");
    idle(4);

    fc = 0;
    for (int i = 0; i < 2500; i++) begin
      stim_t s;
      if ($urandom_range(0, 29) == 0) b.mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 5))
          0: b.tgt = 17'd32768;
          1: b.tgt = 17'd16384;
          2: b.tgt = 17'd0;
          3: b.tgt = 17'd65536;
          4: b.tgt = 17'd131071;
          default: b.tgt = 17'($urandom_range(0, 131071));
        endcase
      end
      s = b;
      s.rst = ($urandom_range(0, 299) == 0);
      s.vs = ((fc % 60) < 3);
      s.hs = ((fc % 20) < 2);
      s.de = !s.vs && !s.hs && ($urandom_range(0, 3) != 0);
      s.data = 24'($urandom);
      s.by = 1'($urandom); s.bc = 1'($urandom); s.bl = 1'($urandom);
      s.pc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(80, 100)) : 8'($urandom);
      s.pl = 8'($urandom);
      applyStimulus(s, 1'b0, 24'h0, "");
      fc++;
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
